// File: rtl/mkio_tx_encoder.sv
// MIL-STD-1553 (MKIO) Manchester transmit encoder: sync, 16 data bits, odd parity.
// Define MKIO_TX_TIMEOUT_EN to build the fail-safe transmit timer.
module mkio_tx_encoder #(
  parameter int unsigned CLK_PER_HALF = 8,
  parameter int unsigned TIMEOUT_CLK  = 12800
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] tx_data,
  input  logic        tx_cd,
  input  logic        tx_ready,
  output logic        busy,
  output logic        tx_p,
  output logic        tx_n,
  output logic        tx_en,
  output logic        done,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} state_t;

  localparam logic [7:0] CNT_LAST = 8'(CLK_PER_HALF - 1);
  localparam logic [7:0] CNT_PRE  = 8'(CLK_PER_HALF - 2);
  localparam logic [5:0] IDX_LAST = 6'd39;

  state_t      state;
  logic [7:0]  cnt;
  logic [5:0]  idx;
  logic [15:0] shreg;
  logic        cd_r;
  logic        par_r;
  logic [15:0] hold_data;
  logic        hold_cd;
  logic        hold_full;

  logic        accept;
  logic        start;
  logic        abort;
  logic [5:0]  nidx;
  logic        nlvl;

  assign busy   = hold_full | timeout;
  assign accept = tx_ready & ~busy;
  assign start  = hold_full & ~abort &
                  ((state == IDLE) || ((cnt == CNT_LAST) && (idx == IDX_LAST)));
  assign nidx   = idx + 6'd1;

  // Line level of the half-bit about to begin; outputs are registered so the
  // level is computed one half-bit ahead from the pre-shift data register.
  always_comb begin
    nlvl = 1'b0;
    if (nidx < 6'd6)
      nlvl = (nidx < 6'd3) ^ cd_r;
    else if (nidx < 6'd38)
      nlvl = ((nidx[0] || (nidx == 6'd6)) ? shreg[15] : shreg[14]) ^ nidx[0];
    else
      nlvl = par_r ^ nidx[0];
  end

`ifdef MKIO_TX_TIMEOUT_EN
  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CLK - 1);

  logic [19:0] tmr;
  logic        tmo_r;

  assign abort   = tx_en & (tmr == TMO_LAST);
  assign timeout = tmo_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr   <= '0;
      tmo_r <= 1'b0;
    end else begin
      tmr <= tx_en ? tmr + 20'd1 : '0;
      if (abort)
        tmo_r <= 1'b1;
    end
  end
`else
  assign abort   = 1'b0;
  // Legal TIMEOUT_CLK is never 0, so this is a constant 0 that keeps the parameter referenced.
  assign timeout = (TIMEOUT_CLK == 0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      cd_r      <= 1'b0;
      par_r     <= 1'b0;
      hold_data <= '0;
      hold_cd   <= 1'b0;
      hold_full <= 1'b0;
      tx_p      <= 1'b0;
      tx_n      <= 1'b0;
      tx_en     <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        hold_data <= tx_data;
        hold_cd   <= tx_cd;
        hold_full <= 1'b1;
      end
      if (abort) begin
        state     <= IDLE;
        cnt       <= '0;
        idx       <= '0;
        hold_full <= 1'b0;
        tx_en     <= 1'b0;
        tx_p      <= 1'b0;
        tx_n      <= 1'b0;
      end else if (start) begin
        // Same path for a load from IDLE and a gapless follow-on word.
        state     <= SYNC;
        cnt       <= '0;
        idx       <= '0;
        shreg     <= hold_data;
        cd_r      <= hold_cd;
        par_r     <= ~^hold_data;
        hold_full <= 1'b0;
        tx_en     <= 1'b1;
        tx_p      <= ~hold_cd;
        tx_n      <= hold_cd;
      end else if (state == IDLE) begin
        cnt <= '0;
      end else if (cnt != CNT_LAST) begin
        cnt <= cnt + 8'd1;
        if ((idx == IDX_LAST) && (cnt == CNT_PRE))
          done <= 1'b1;
      end else if (idx == IDX_LAST) begin
        state <= IDLE;
        cnt   <= '0;
        idx   <= '0;
        tx_en <= 1'b0;
        tx_p  <= 1'b0;
        tx_n  <= 1'b0;
      end else begin
        cnt  <= '0;
        idx  <= nidx;
        tx_p <= nlvl;
        tx_n <= ~nlvl;
        if (nidx == 6'd6)
          state <= DATA;
        else if (nidx == 6'd38)
          state <= PARITY;
        if ((state == DATA) && idx[0])
          shreg <= {shreg[14:0], 1'b0};
      end
    end
  end

endmodule
